// File: rtl/ram_read_data.sv
// ram_read_data -- burst read engine for a synchronous RAM with fixed read latency.
//
// A start pulse in IDLE latches a base address and a word count. The engine then
// issues one registered read per cycle at consecutive (wrapping) addresses, tracks
// the outstanding reads in a RD_LATENCY-deep shift register, captures each returned
// word into o_data_rd with o_data_vld, and pulses o_done once the last word is out.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (clears FSM, in-flight pipe, outputs)
//   i_rd_start   start pulse, only honoured in IDLE
//   i_base_addr  first read address, latched with i_rd_start
//   i_len        number of words to read, latched with i_rd_start (0 = empty burst)
//   i_ram_rdata  RAM read data, valid RD_LATENCY cycles after o_ram_rd_en
//   o_ram_rd_en  RAM read strobe (registered)
//   o_ram_addr   RAM read address (registered)
//   o_data_rd    captured read word, holds its value between valid strobes
//   o_data_vld   o_data_rd carries a new word this cycle
//   o_busy       FSM is not IDLE
//   o_done       one-cycle pulse at burst end
module ram_read_data #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_ADDR  = 8,
  parameter int SIZE_LEN   = 8,
  parameter int RD_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rd_start,
  input  logic [SIZE_ADDR-1:0] i_base_addr,
  input  logic [SIZE_LEN-1:0]  i_len,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_ram_rd_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_data_rd,
  output logic                 o_data_vld,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam logic [SIZE_LEN-1:0]  LEN_ONE  = 1;
  localparam logic [SIZE_ADDR-1:0] ADDR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [SIZE_LEN-1:0]  remain, remain_nxt;   // reads still to issue after the current one
  logic                 rd_en_nxt;
  logic [SIZE_ADDR-1:0] addr_nxt;
  logic [RD_LATENCY-1:0] vld_p;               // in-flight reads, oldest at the top bit
  logic                 cap_en;

  assign cap_en = vld_p[RD_LATENCY-1];

  always_comb begin
    state_nxt  = state;
    remain_nxt = remain;
    rd_en_nxt  = 1'b0;
    addr_nxt   = o_ram_addr;
    unique case (state)
      IDLE: begin
        if (i_rd_start) begin
          if (i_len != '0) begin
            state_nxt  = ISSUE;
            rd_en_nxt  = 1'b1;
            addr_nxt   = i_base_addr;
            remain_nxt = i_len - LEN_ONE;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        // The read for the current cycle is already on the port; decide the next one.
        if (remain == '0) begin
          state_nxt = DRAIN;
        end else begin
          rd_en_nxt  = 1'b1;
          addr_nxt   = o_ram_addr + ADDR_ONE;
          remain_nxt = remain - LEN_ONE;
        end
      end
      DRAIN: begin
        // Empty pipe means the last word was captured at the previous edge and is on o_data_rd now.
        if (vld_p == '0) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      remain      <= '0;
      o_ram_rd_en <= 1'b0;
      o_ram_addr  <= '0;
    end else begin
      state       <= state_nxt;
      remain      <= remain_nxt;
      o_ram_rd_en <= rd_en_nxt;
      o_ram_addr  <= addr_nxt;
    end
  end

  // stage: read issue -> in-flight tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= o_ram_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // stage: RAM return -> output capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_data_vld <= 1'b0;
      o_data_rd  <= '0;
    end else begin
      o_data_vld <= cap_en;
      if (cap_en) o_data_rd <= i_ram_rdata;
    end
  end

  assign o_busy = (state != IDLE);
  assign o_done = (state == DONE);

endmodule

// File: tb/tb_ram_read_data.sv
// tb_ram_read_data -- directed bench for ram_read_data.
// Two instances: dut2 (RD_LATENCY=2) for the timing scenarios, dut1 (RD_LATENCY=1)
// for the full-length burst. Each RAM model returns addr+0x40 after its latency.
// Cycle n is the cycle after clock edge n; a start driven during cycle 0 is
// sampled at edge 1, so the first read appears in cycle 1.
module tb_ram_read_data;

  logic       clk = 1'b0;
  logic       rst, start2, start1;
  logic [7:0] base, len;

  logic       en2, vld2, done2, busy2;
  logic [7:0] addr2, data2, rdata2;
  logic       en1, vld1, done1, busy1;
  logic [7:0] addr1, data1, rdata1;
  logic [7:0] ram2_q0, ram2_q1;

  int total = 0;
  int bad   = 0;

  logic       r_en   [0:31];
  logic [7:0] r_addr [0:31];
  logic       r_vld  [0:31];
  logic [7:0] r_data [0:31];
  logic       r_done [0:31];
  logic       r_busy [0:31];

  always #5 clk = ~clk;

  ram_read_data #(.SIZE_DATA(8), .SIZE_ADDR(8), .SIZE_LEN(8), .RD_LATENCY(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_rd_start(start2), .i_base_addr(base), .i_len(len),
    .i_ram_rdata(rdata2), .o_ram_rd_en(en2), .o_ram_addr(addr2), .o_data_rd(data2),
    .o_data_vld(vld2), .o_busy(busy2), .o_done(done2)
  );

  ram_read_data #(.SIZE_DATA(8), .SIZE_ADDR(8), .SIZE_LEN(8), .RD_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_rd_start(start1), .i_base_addr(base), .i_len(len),
    .i_ram_rdata(rdata1), .o_ram_rd_en(en1), .o_ram_addr(addr1), .o_data_rd(data1),
    .o_data_vld(vld1), .o_busy(busy1), .o_done(done1)
  );

  // RAM models: data = addr + 0x40 after the configured latency
  always @(posedge clk) begin
    ram2_q0 <= addr2 + 8'h40;
    ram2_q1 <= ram2_q0;
    rdata1  <= addr1 + 8'h40;
  end
  assign rdata2 = ram2_q1;

  // Expected outputs in cycle c for a latency-2 burst of n>0 words whose first read is in cycle s.
  function automatic logic [19:0] exp_burst(input int c, input int s, input int n, input logic [7:0] b);
    logic       e_en, e_v, e_dn, e_bz;
    logic [7:0] e_a, e_d;
    e_en = (c >= s) && (c < s + n);
    e_a  = e_en ? b + 8'(c - s) : 8'h00;
    e_v  = (c >= s + 3) && (c < s + n + 3);
    e_d  = e_v ? b + 8'h40 + 8'(c - s - 3) : 8'h00;
    e_dn = (c == s + n + 3);
    e_bz = (c >= s) && (c <= s + n + 3);
    return {e_en, e_a, e_v, e_d, e_dn, e_bz};
  endfunction

  function automatic logic [19:0] act_at(input int c);
    return {r_en[c], r_en[c] ? r_addr[c] : 8'h00, r_vld[c], r_vld[c] ? r_data[c] : 8'h00,
            r_done[c], r_busy[c]};
  endfunction

  // Start dut2 in cycle 0, record cycles 1..ncyc; optional extra starts (base xb) and a reset cycle.
  task automatic run2(input logic [7:0] b, input logic [7:0] l, input int ncyc,
                      input int xs1, input int xs2, input logic [7:0] xb, input int rc);
    @(negedge clk);
    start2 = 1'b1;
    base   = b;
    len    = l;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      r_en[c]   = en2;
      r_addr[c] = addr2;
      r_vld[c]  = vld2;
      r_data[c] = data2;
      r_done[c] = done2;
      r_busy[c] = busy2;
      start2 = (c == xs1) || (c == xs2);
      if (start2) base = xb;
      rst = (c == rc);
    end
    start2 = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(3);
    total++;
    if ({en2, addr2, data2, vld2, busy2, done2} !== 20'h0) begin
      bad++;
      $display("FAIL reset_dut2 got=%h want=0", {en2, addr2, data2, vld2, busy2, done2});
    end
    total++;
    if ({en1, addr1, data1, vld1, busy1, done1} !== 20'h0) begin
      bad++;
      $display("FAIL reset_dut1 got=%h want=0", {en1, addr1, data1, vld1, busy1, done1});
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic;
    run2(8'h10, 8'd4, 10, 0, 0, 8'h00, 0);
    for (int c = 1; c <= 10; c++) begin
      total++;
      if (act_at(c) !== exp_burst(c, 1, 4, 8'h10)) begin
        bad++;
        $display("FAIL basic c=%0d got=%h want=%h", c, act_at(c), exp_burst(c, 1, 4, 8'h10));
      end
    end
    total++;
    if (r_data[10] !== 8'h53) begin
      bad++;
      $display("FAIL basic_hold got=%h want=53", r_data[10]);
    end
    idle(4);
  endtask

  task automatic test_wrap;
    run2(8'hFE, 8'd3, 9, 0, 0, 8'h00, 0);
    for (int c = 1; c <= 9; c++) begin
      total++;
      if (act_at(c) !== exp_burst(c, 1, 3, 8'hFE)) begin
        bad++;
        $display("FAIL wrap c=%0d got=%h want=%h", c, act_at(c), exp_burst(c, 1, 3, 8'hFE));
      end
    end
    idle(4);
  endtask

  task automatic test_zero_len;
    logic [19:0] want;
    run2(8'h33, 8'd0, 4, 0, 0, 8'h00, 0);
    for (int c = 1; c <= 4; c++) begin
      want = {18'h0, (c == 1), (c == 1)};
      total++;
      if (act_at(c) !== want) begin
        bad++;
        $display("FAIL zero_len c=%0d got=%h want=%h", c, act_at(c), want);
      end
    end
    idle(3);
  endtask

  task automatic test_back_to_back;
    logic [19:0] want;
    len = 8'd4;
    run2(8'h10, 8'd4, 12, 3, 9, 8'h80, 0);
    for (int c = 1; c <= 12; c++) begin
      want = (c <= 9) ? exp_burst(c, 1, 4, 8'h10) : exp_burst(c, 10, 4, 8'h80);
      total++;
      if (act_at(c) !== want) begin
        bad++;
        $display("FAIL back_to_back c=%0d got=%h want=%h", c, act_at(c), want);
      end
    end
    idle(12);
  endtask

  task automatic test_mid_reset;
    logic [19:0] want;
    run2(8'h10, 8'd4, 14, 6, 0, 8'h80, 5);
    for (int c = 1; c <= 14; c++) begin
      want = (c <= 5) ? exp_burst(c, 1, 4, 8'h10) : exp_burst(c, 7, 4, 8'h80);
      total++;
      if (act_at(c) !== want) begin
        bad++;
        $display("FAIL mid_reset c=%0d got=%h want=%h", c, act_at(c), want);
      end
    end
    total++;
    if ({r_addr[6], r_data[6]} !== 16'h0) begin
      bad++;
      $display("FAIL mid_reset_regs got=%h want=0", {r_addr[6], r_data[6]});
    end
    idle(4);
  endtask

  task automatic test_long_burst;
    int nv, nd, first_v, last_v, done_c;
    nv = 0; nd = 0; first_v = -1; last_v = -1; done_c = -1;
    @(negedge clk);
    start1 = 1'b1;
    base   = 8'hC0;
    len    = 8'd255;
    for (int c = 1; c <= 262; c++) begin
      @(negedge clk);
      start1 = 1'b0;
      if (vld1) begin
        total++;
        if (data1 !== 8'(8'hC0 + 8'h40 + nv)) begin
          bad++;
          $display("FAIL long_data k=%0d got=%h want=%h", nv, data1, 8'(8'hC0 + 8'h40 + nv));
        end
        if (first_v < 0) first_v = c;
        last_v = c;
        nv++;
      end
      if (done1) begin
        nd++;
        done_c = c;
      end
    end
    total++;
    if (nv !== 255 || first_v !== 3 || last_v !== 257) begin
      bad++;
      $display("FAIL long_vld count=%0d first=%0d last=%0d want 255/3/257", nv, first_v, last_v);
    end
    total++;
    if (nd !== 1 || done_c !== 258) begin
      bad++;
      $display("FAIL long_done count=%0d cycle=%0d want 1/258", nd, done_c);
    end
  endtask

  initial begin
    rst = 1'b1; start2 = 1'b0; start1 = 1'b0; base = 8'h00; len = 8'h00;
    test_reset;
    test_basic;
    test_wrap;
    test_zero_len;
    test_back_to_back;
    test_mid_reset;
    test_long_burst;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
